// File: rtl/sync_debouncer_if.sv
// Bundle of the debouncer's enable, input bus and result signals.
//   master : upstream side; drives en_i and data_synced_i, observes the results
//   slave  : debouncer side; consumes en_i and data_synced_i, drives
//            data_stable_o, rise_pulse_o, fall_pulse_o and busy_o
// DATA_WIDTH must match the DATA_WIDTH of the attached sync_debouncer.
interface sync_debouncer_if #(
  parameter int DATA_WIDTH = 1
);
  logic                  en_i;
  logic [DATA_WIDTH-1:0] data_synced_i;
  logic [DATA_WIDTH-1:0] data_stable_o;
  logic [DATA_WIDTH-1:0] rise_pulse_o;
  logic [DATA_WIDTH-1:0] fall_pulse_o;
  logic                  busy_o;

  modport master (
    output en_i, data_synced_i,
    input  data_stable_o, rise_pulse_o, fall_pulse_o, busy_o
  );

  modport slave (
    input  en_i, data_synced_i,
    output data_stable_o, rise_pulse_o, fall_pulse_o, busy_o
  );
endinterface

// File: rtl/sync_debouncer.sv
// Per-bit debounce and edge detect for an already-synchronized bus.
// A bit of data_stable_o takes a new value only after data_synced_i has
// differed from it on DEBOUNCE_CYCLES consecutive enabled cycles; the
// accepting edge also raises a one-cycle rise or fall pulse for that bit.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset, dominates en_i and any count
//   bus    : sync_debouncer_if.slave
//              en_i          sample enable strobe
//              data_synced_i synchronized raw inputs
//              data_stable_o debounced levels (registered)
//              rise_pulse_o  accepted 0->1 change (registered, one cycle)
//              fall_pulse_o  accepted 1->0 change (registered, one cycle)
//              busy_o        some channel has a count in progress
//
// Per-channel states (implicit in the counter value):
//   state    | meaning
//   STABLE   | cnt == 0, input agrees with the stable level
//   COUNTING | cnt >  0, input has differed on cnt consecutive enabled samples
module sync_debouncer #(
  parameter int DLY             = 1,
  parameter int DATA_WIDTH      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 8,
  parameter int RESET_LEVEL     = 0
) (
  input logic            clk_i,
  input logic            rst_i,
  sync_debouncer_if.slave bus
);

  // DLY is accepted so existing instantiations keep elaborating; the
  // registers themselves are delay-free.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_WIDTH) - 1) begin : g_bad_cycles
    $error("sync_debouncer: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
  end
  if (RESET_LEVEL != 0 && RESET_LEVEL != 1) begin : g_bad_level
    $error("sync_debouncer: RESET_LEVEL must be 0 or 1");
  end
  if (DLY < 0) begin : g_bad_dly
    $error("sync_debouncer: DLY must not be negative");
  end

  localparam logic [CNT_WIDTH-1:0]  CNT_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] STABLE_RST = (RESET_LEVEL != 0) ? '1 : '0;

  logic [CNT_WIDTH-1:0]  cnt [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] stable;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;
  logic                  busy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable <= STABLE_RST;
      rise   <= '0;
      fall   <= '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // Pulses default low every clock, so a disabled cycle right after an
      // acceptance still ends the pulse.
      rise <= '0;
      fall <= '0;
      if (bus.en_i) begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
          if (bus.data_synced_i[i] == stable[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            stable[i] <= bus.data_synced_i[i];
            rise[i]   <= bus.data_synced_i[i];
            fall[i]   <= ~bus.data_synced_i[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (cnt[i] != '0) busy = 1'b1;
    end
  end

  assign bus.data_stable_o = stable;
  assign bus.rise_pulse_o  = rise;
  assign bus.fall_pulse_o  = fall;
  assign bus.busy_o        = busy;

endmodule

// File: tb/tb_sync_debouncer.sv
module tb_sync_debouncer;

  // Four instances: 0: N=4 RL=0, 1: N=3 RL=1 (counter at its max), 2: N=1, 3: N=8
  localparam int ND = 4;

  logic       clk = 1'b0;
  logic       rst [ND];
  logic       en  [ND];
  logic [3:0] din [ND];
  logic [3:0] st  [ND];
  logic [3:0] ri  [ND];
  logic [3:0] fa  [ND];
  logic       bz  [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : gd
    sync_debouncer_if #(.DATA_WIDTH(4)) bus ();
    sync_debouncer #(
      .DLY             (1),
      .DATA_WIDTH      (4),
      .DEBOUNCE_CYCLES (g == 0 ? 4 : g == 1 ? 3 : g == 2 ? 1 : 8),
      .CNT_WIDTH       (g == 0 ? 8 : g == 1 ? 2 : g == 2 ? 1 : 4),
      .RESET_LEVEL     (g == 1 ? 1 : 0)
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst[g]),
      .bus   (bus)
    );
    assign bus.en_i          = en[g];
    assign bus.data_synced_i = din[g];
    assign st[g] = bus.data_stable_o;
    assign ri[g] = bus.rise_pulse_o;
    assign fa[g] = bus.fall_pulse_o;
    assign bz[g] = bus.busy_o;
  end

  function automatic int nof(int d);
    return (d == 0) ? 4 : (d == 1) ? 3 : (d == 2) ? 1 : 8;
  endfunction

  function automatic int rlof(int d);
    return (d == 1) ? 1 : 0;
  endfunction

  // Reference model: keeps the history of enabled samples since reset and
  // accepts a new level once the most recent N samples all disagree with it.
  logic [31:0] hist [ND][4];
  int          nval [ND][4];
  logic [3:0]  m_st [ND];
  logic [3:0]  m_ri [ND];
  logic [3:0]  m_fa [ND];
  logic        m_bz [ND];

  int checks = 0;
  int errors = 0;

  function automatic int trail(int d, int c);
    int k = 0;
    while (k < nval[d][c] && k < 32 && hist[d][c][k] != m_st[d][c]) k++;
    return k;
  endfunction

  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      m_ri[d] = 4'h0;
      m_fa[d] = 4'h0;
      if (rst[d]) begin
        m_st[d] = (rlof(d) != 0) ? 4'hF : 4'h0;
        for (int c = 0; c < 4; c++) begin
          hist[d][c] = '0;
          nval[d][c] = 0;
        end
      end else if (en[d]) begin
        for (int c = 0; c < 4; c++) begin
          hist[d][c] = {hist[d][c][30:0], din[d][c]};
          if (nval[d][c] < 31) nval[d][c]++;
          if (trail(d, c) >= nof(d)) begin
            m_st[d][c] = din[d][c];
            m_ri[d][c] = din[d][c];
            m_fa[d][c] = ~din[d][c];
          end
        end
      end
      m_bz[d] = 1'b0;
      for (int c = 0; c < 4; c++) if (trail(d, c) > 0) m_bz[d] = 1'b1;
    end
  endtask

  task automatic chk(string nm, logic [3:0] got, logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%b expected=%b", nm, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("model_stable[%0d]", d), st[d], m_st[d]);
      chk($sformatf("model_rise[%0d]", d), ri[d], m_ri[d]);
      chk($sformatf("model_fall[%0d]", d), fa[d], m_fa[d]);
      chk($sformatf("model_busy[%0d]", d), {3'b0, bz[d]}, {3'b0, m_bz[d]});
      chk($sformatf("pulse_overlap[%0d]", d), ri[d] & fa[d], 4'h0);
    end
  endtask

  // Inputs are set at the falling edge; one step = one rising edge, then
  // outputs are sampled at the next falling edge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] din;
    logic [3:0] st;
    logic [3:0] ri;
    logic [3:0] fa;
    logic       bz;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic e, logic [3:0] d, logic [3:0] s,
                              logic [3:0] rp, logic [3:0] fp, logic b);
    vec_t v;
    v.rst = r; v.en = e; v.din = d; v.st = s; v.ri = rp; v.fa = fp; v.bz = b;
    return v;
  endfunction

  initial begin
    logic prev;
    logic val;

    // Instance 0 (N=4): clean rise, glitch rejection, clean fall, enable gating
    tbl.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h1, 4'h1, 4'h1, 4'h0, 0));
    tbl.push_back(mk(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 4'h0, 4'h1, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h1, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h1, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 4'h0, 4'h1, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h1, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h1, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 4'h1, 0));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'h1, 4'h1, 4'h1, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h1, 4'h1, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 0));

    @(negedge clk);
    foreach (tbl[i]) begin
      for (int d = 0; d < ND; d++) begin
        rst[d] = tbl[i].rst;
        en[d]  = tbl[i].en;
        din[d] = tbl[i].din;
      end
      step();
      chk($sformatf("tbl%0d_stable", i), st[0], tbl[i].st);
      chk($sformatf("tbl%0d_rise", i), ri[0], tbl[i].ri);
      chk($sformatf("tbl%0d_fall", i), fa[0], tbl[i].fa);
      chk($sformatf("tbl%0d_busy", i), {3'b0, bz[0]}, {3'b0, tbl[i].bz});
    end

    // Channel independence on instance 1 (N=3, reset level 1)
    rst[1] = 1; en[1] = 1; din[1] = 4'b1110;
    step();
    chk("ind_reset_level", st[1], 4'b1111);
    rst[1] = 0;
    step();
    step();
    chk("ind_prep_busy", {3'b0, bz[1]}, 4'h1);
    step();
    chk("ind_prep_fall", fa[1], 4'b0001);
    chk("ind_prep_stable", st[1], 4'b1110);
    din[1] = 4'b1101; step();
    din[1] = 4'b1001; step();
    chk("ind_c2_stable", st[1], 4'b1110);
    chk("ind_c2_busy", {3'b0, bz[1]}, 4'h1);
    din[1] = 4'b1011; step();
    chk("ind_c3_rise", ri[1], 4'b0001);
    chk("ind_c3_fall", fa[1], 4'b0000);
    chk("ind_c3_stable", st[1], 4'b1111);
    step();
    chk("ind_c4_rise", ri[1], 4'b0000);
    chk("ind_c4_fall", fa[1], 4'b0100);
    chk("ind_c4_stable", st[1], 4'b1011);
    step();
    chk("ind_c5_fall", fa[1], 4'b0000);
    chk("ind_c5_busy", {3'b0, bz[1]}, 4'h0);

    // Reset in the middle of a count on instance 3 (N=8)
    rst[3] = 1; en[3] = 1; din[3] = 4'h0;
    step();
    rst[3] = 0; din[3] = 4'h1;
    repeat (5) step();
    chk("rstmid_busy_before", {3'b0, bz[3]}, 4'h1);
    rst[3] = 1;
    step();
    chk("rstmid_busy_cleared", {3'b0, bz[3]}, 4'h0);
    chk("rstmid_stable_cleared", st[3], 4'h0);
    rst[3] = 0;
    repeat (7) step();
    chk("rstmid_edge7_stable", st[3], 4'h0);
    chk("rstmid_edge7_busy", {3'b0, bz[3]}, 4'h1);
    step();
    chk("rstmid_edge8_stable", st[3], 4'h1);
    chk("rstmid_edge8_rise", ri[3], 4'h1);

    // Pass-through with edge pulses on instance 2 (N=1)
    rst[2] = 1; en[2] = 1; din[2] = 4'h0;
    step();
    rst[2] = 0;
    prev = 1'b0;
    for (int k = 0; k < 12; k++) begin
      val = ((k >> 1) & 1) == 0;
      din[2] = {3'b000, val};
      step();
      chk($sformatf("n1_k%0d_stable", k), st[2], {3'b000, val});
      chk($sformatf("n1_k%0d_rise", k), ri[2], {3'b000, val & ~prev});
      chk($sformatf("n1_k%0d_fall", k), fa[2], {3'b000, ~val & prev});
      prev = val;
    end

    // Random traffic on every instance against the model
    for (int n = 0; n < 800; n++) begin
      for (int d = 0; d < ND; d++) begin
        rst[d] = ($urandom_range(0, 80) == 0);
        en[d]  = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(0, 5) == 0) din[d][c] = ~din[d][c];
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
